// File: rtl/seg7_scan_if.sv
// Bundle of the count-control inputs and display/count outputs of seg7_scan_counter.
// The master drives the controls; the slave (the counter) drives the display and count.
interface seg7_scan_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  ena;
    logic [1:0]            mode;
    logic [4*DIGITS-1:0]   load_val;
    logic [6:0]            segments;
    logic                  dp;
    logic [DIGITS-1:0]     digit_sel;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;

    modport master (
        output ena, mode, load_val,
        input  segments, dp, digit_sel, count, wrap
    );

    modport slave (
        input  ena, mode, load_val,
        output segments, dp, digit_sel, count, wrap
    );
endinterface

// File: rtl/seg7_scan_counter.sv
// N-digit BCD up/down/load counter with a time-multiplexed seven-segment scan,
// leading-zero blanking and selectable common-anode output polarity.
module seg7_scan_counter #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned TICK_DIV     = 1000,
    parameter int unsigned SCAN_DIV     = 256,
    parameter int unsigned LZB          = 1,
    parameter int unsigned COMMON_ANODE = 0
) (
    input logic       clk,
    input logic       rst_n,
    seg7_scan_if.slave bus
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CW = 4 * DIGITS;

    localparam logic [PW-1:0] PresMax = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] ScanMax = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IdxMax  = IW'(DIGITS - 1);

    localparam logic [1:0] ModeUp   = 2'b01;
    localparam logic [1:0] ModeDown = 2'b10;
    localparam logic [1:0] ModeLoad = 2'b11;

    logic [PW-1:0]     pres_q, pres_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wrap_q, wrap_d;
    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              dp_q, dp_d;

    logic       counting, tick, carry;
    logic [3:0] nib;

    always_comb begin
        counting = bus.ena && (bus.mode == ModeUp || bus.mode == ModeDown);
        tick     = counting && (pres_q == PresMax);
        pres_d   = (counting && !tick) ? pres_q + 1'b1 : '0;
        count_d  = count_q;
        wrap_d   = 1'b0;
        carry    = 1'b1;
        nib      = 4'd0;
        if (tick) begin
            // Ripple carry/borrow: a digit changes only while all lower digits rolled over.
            for (int i = 0; i < DIGITS; i++) begin
                nib = count_q[4*i +: 4];
                if (carry) begin
                    if (bus.mode == ModeUp) begin
                        if (nib == 4'd9) nib = 4'd0;
                        else begin
                            nib   = nib + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) nib = 4'd9;
                        else begin
                            nib   = nib - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
                count_d[4*i +: 4] = nib;
            end
            wrap_d = carry;
        end else if (bus.ena && bus.mode == ModeLoad) begin
            for (int i = 0; i < DIGITS; i++) begin
                nib               = bus.load_val[4*i +: 4];
                count_d[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            end
        end
    end

    always_comb begin
        scan_d = (scan_q == ScanMax) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == ScanMax) idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
    end

    logic [3:0] digit;
    logic       upper_zero, blank;
    logic [6:0] pattern;

    always_comb begin
        digit      = 4'd0;
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_q) digit = count_q[4*i +: 4];
            if (IW'(i) >= idx_q && count_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
        end
        blank = (LZB != 0) && (idx_q != '0) && upper_zero;
        case (digit)
            4'd0:    pattern = 7'h3F;
            4'd1:    pattern = 7'h06;
            4'd2:    pattern = 7'h5B;
            4'd3:    pattern = 7'h4F;
            4'd4:    pattern = 7'h66;
            4'd5:    pattern = 7'h6D;
            4'd6:    pattern = 7'h7D;
            4'd7:    pattern = 7'h07;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h6F;
            default: pattern = 7'h00;
        endcase
        seg_d = blank ? 7'h00 : pattern;
        sel_d = DIGITS'(1) << idx_q;
        dp_d  = !blank && (bus.mode == ModeDown);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres_q  <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h3F;
            sel_q   <= DIGITS'(1);
            dp_q    <= 1'b0;
        end else begin
            pres_q  <= pres_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
            dp_q    <= dp_d;
        end
    end

    assign bus.segments  = (COMMON_ANODE != 0) ? ~seg_q : seg_q;
    assign bus.digit_sel = (COMMON_ANODE != 0) ? ~sel_q : sel_q;
    assign bus.dp        = (COMMON_ANODE != 0) ? ~dp_q : dp_q;
    assign bus.count     = count_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_seg7_scan_counter.sv
// Self-checking bench for seg7_scan_counter: directed scenarios plus a randomized run,
// all checked against a decimal-arithmetic reference model.
module tb_seg7_scan_counter;
    localparam int unsigned Digits = 4;
    localparam int          MaxV   = 10000;
    localparam int          TickDiv = 4;
    localparam int          ScanDiv = 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    seg7_scan_if #(.DIGITS(Digits)) bus ();
    seg7_scan_if #(.DIGITS(Digits)) bus_ca ();

    assign bus_ca.ena      = bus.ena;
    assign bus_ca.mode     = bus.mode;
    assign bus_ca.load_val = bus.load_val;

    seg7_scan_counter #(
        .DIGITS(Digits), .TICK_DIV(TickDiv), .SCAN_DIV(ScanDiv), .LZB(1), .COMMON_ANODE(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    seg7_scan_counter #(
        .DIGITS(Digits), .TICK_DIV(TickDiv), .SCAN_DIV(ScanDiv), .LZB(1), .COMMON_ANODE(1)
    ) dut_ca (
        .clk(clk), .rst_n(rst_n), .bus(bus_ca)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: count held as a plain decimal integer.
    int         m_count, m_pres, m_scan, m_idx;
    bit         m_wrap, m_dp;
    logic [6:0] m_seg;
    logic [3:0] m_sel;

    function automatic int pow10(input int k);
        int r = 1;
        for (int i = 0; i < k; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] lv);
        int v = 0;
        int d;
        for (int i = 0; i < 4; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * pow10(i);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0; m_pres = 0; m_scan = 0; m_idx = 0;
        m_wrap = 0; m_dp = 0; m_seg = 7'h3F; m_sel = 4'b0001;
    endtask

    // One clock: predict next state from current inputs, then sample 1 time unit after the edge.
    task automatic cycle();
        int  d, nc, np, ns, ni;
        bit  blank, counting, tick, nw;
        logic [6:0] e_seg;
        logic [3:0] e_sel;
        bit  e_dp;
        d        = (m_count / pow10(m_idx)) % 10;
        blank    = (m_idx > 0) && (m_count < pow10(m_idx));
        e_seg    = blank ? 7'h00 : seg_tab[d];
        e_sel    = 4'(1 << m_idx);
        e_dp     = !blank && (bus.mode == 2'b10);
        counting = bus.ena && (bus.mode == 2'b01 || bus.mode == 2'b10);
        tick     = counting && (m_pres == TickDiv - 1);
        np       = (counting && !tick) ? m_pres + 1 : 0;
        nc       = m_count;
        nw       = 0;
        if (tick && bus.mode == 2'b01) begin
            nc = (m_count + 1) % MaxV;
            nw = (m_count == MaxV - 1);
        end else if (tick && bus.mode == 2'b10) begin
            nc = (m_count == 0) ? MaxV - 1 : m_count - 1;
            nw = (m_count == 0);
        end else if (bus.ena && bus.mode == 2'b11) begin
            nc = clamp_val(bus.load_val);
        end
        ns = (m_scan + 1) % ScanDiv;
        ni = (m_scan == ScanDiv - 1) ? (m_idx + 1) % Digits : m_idx;
        @(posedge clk);
        #1;
        m_count = nc; m_pres = np; m_wrap = nw; m_scan = ns; m_idx = ni;
        m_seg = e_seg; m_sel = e_sel; m_dp = e_dp;
    endtask

    task automatic set_in(input logic e, input logic [1:0] m, input logic [15:0] lv);
        bus.ena = e; bus.mode = m; bus.load_val = lv;
    endtask

    task automatic test_reset();
        set_in(1'b1, 2'b01, 16'h0000);
        repeat (6) cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (bus.count !== 16'h0000) $display("FAIL reset_count: got %h want 0000", bus.count); else n_pass++;
        n_checks++; if (bus.segments !== 7'h3F) $display("FAIL reset_seg: got %h want 3f", bus.segments); else n_pass++;
        n_checks++; if (bus.digit_sel !== 4'b0001) $display("FAIL reset_sel: got %b want 0001", bus.digit_sel); else n_pass++;
        n_checks++; if (bus.wrap !== 1'b0 || bus.dp !== 1'b0) $display("FAIL reset_wrap_dp: got %b%b want 00", bus.wrap, bus.dp); else n_pass++;
        n_checks++; if (bus_ca.segments !== 7'h40 || bus_ca.digit_sel !== 4'b1110 || bus_ca.dp !== 1'b1)
            $display("FAIL reset_ca: got %h %b %b want 40 1110 1", bus_ca.segments, bus_ca.digit_sel, bus_ca.dp);
        else n_pass++;
        set_in(1'b0, 2'b00, 16'h0000);
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.count !== 16'h0000) $display("FAIL reset_hold_count: got %h want 0000", bus.count); else n_pass++;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_up();
        set_in(1'b1, 2'b01, 16'h0000);
        for (int c = 1; c <= 40; c++) begin
            cycle();
            n_checks++; if (bus.count !== to_bcd(m_count)) $display("FAIL up_count c%0d: got %h want %h", c, bus.count, to_bcd(m_count)); else n_pass++;
            if (c == 4) begin
                n_checks++; if (bus.count !== 16'h0001) $display("FAIL up_first_step: got %h want 0001", bus.count); else n_pass++;
            end
            if (c == 36) begin
                n_checks++; if (bus.count !== 16'h0009) $display("FAIL up_nine: got %h want 0009", bus.count); else n_pass++;
            end
            if (c == 40) begin
                n_checks++; if (bus.count !== 16'h0010) $display("FAIL up_carry: got %h want 0010", bus.count); else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        int pulses;
        set_in(1'b1, 2'b11, 16'h9999);
        cycle();
        n_checks++; if (bus.count !== 16'h9999) $display("FAIL wrap_load: got %h want 9999", bus.count); else n_pass++;
        bus.mode = 2'b01;
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            cycle();
            if (bus.wrap === 1'b1) pulses++;
            n_checks++; if (bus.wrap !== m_wrap) $display("FAIL wrap_up_pulse c%0d: got %b want %b", c, bus.wrap, m_wrap); else n_pass++;
            if (c == 4) begin
                n_checks++; if (bus.count !== 16'h0000 || bus.wrap !== 1'b1) $display("FAIL wrap_up: got %h %b want 0000 1", bus.count, bus.wrap); else n_pass++;
            end
        end
        n_checks++; if (pulses != 1) $display("FAIL wrap_up_width: got %0d pulses want 1", pulses); else n_pass++;
        set_in(1'b1, 2'b11, 16'h0000);
        cycle();
        bus.mode = 2'b10;
        for (int c = 1; c <= 6; c++) begin
            cycle();
            n_checks++; if (bus.wrap !== m_wrap || bus.count !== to_bcd(m_count))
                $display("FAIL wrap_down c%0d: got %h %b want %h %b", c, bus.count, bus.wrap, to_bcd(m_count), m_wrap);
            else n_pass++;
            if (c == 4) begin
                n_checks++; if (bus.count !== 16'h9999 || bus.wrap !== 1'b1) $display("FAIL wrap_down_value: got %h %b want 9999 1", bus.count, bus.wrap); else n_pass++;
            end
        end
        n_checks++; if (bus.dp !== 1'b1 || bus_ca.dp !== 1'b0) $display("FAIL down_dp: got %b %b want 1 0", bus.dp, bus_ca.dp); else n_pass++;
    endtask

    task automatic test_load_clamp();
        set_in(1'b1, 2'b11, 16'hA5F3);
        cycle();
        n_checks++; if (bus.count !== 16'h9593) $display("FAIL load_clamp: got %h want 9593", bus.count); else n_pass++;
        set_in(1'b0, 2'b11, 16'h1234);
        repeat (3) cycle();
        n_checks++; if (bus.count !== 16'h9593) $display("FAIL load_ena0: got %h want 9593", bus.count); else n_pass++;
        n_checks++; if (bus.wrap !== 1'b0) $display("FAIL load_nowrap: got %b want 0", bus.wrap); else n_pass++;
    endtask

    task automatic test_scan_lzb();
        logic [3:0] exp_sel [8] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010,
                                    4'b0100, 4'b0100, 4'b1000, 4'b1000};
        logic [6:0] exp_seg [8] = '{7'h5B, 7'h5B, 7'h66, 7'h66, 7'h00, 7'h00, 7'h00, 7'h00};
        logic [3:0] prev;
        bit found;
        set_in(1'b1, 2'b11, 16'h0042);
        cycle();
        bus.mode = 2'b00;
        found = 0;
        prev  = bus.digit_sel;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            if (bus.digit_sel === 4'b0001 && prev !== 4'b0001) found = 1;
            else prev = bus.digit_sel;
        end
        n_checks++; if (!found) $display("FAIL scan_sync: digit_sel never reached 0001, got %b", bus.digit_sel); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cycle();
            n_checks++; if (bus.digit_sel !== exp_sel[k] || bus.segments !== exp_seg[k])
                $display("FAIL scan_lzb k%0d: got %b %h want %b %h", k, bus.digit_sel, bus.segments, exp_sel[k], exp_seg[k]);
            else n_pass++;
            n_checks++; if (bus_ca.digit_sel !== ~exp_sel[k] || bus_ca.segments !== ~exp_seg[k] || bus_ca.dp !== 1'b1)
                $display("FAIL scan_ca k%0d: got %b %h %b want %b %h 1", k, bus_ca.digit_sel, bus_ca.segments, bus_ca.dp, ~exp_sel[k], ~exp_seg[k]);
            else n_pass++;
        end
    endtask

    task automatic test_hold_ena();
        set_in(1'b1, 2'b01, 16'h0000);
        repeat (2) cycle();
        bus.mode = 2'b00;
        repeat (20) cycle();
        n_checks++; if (bus.count !== 16'h0042) $display("FAIL hold_count: got %h want 0042", bus.count); else n_pass++;
        bus.mode = 2'b01;
        for (int c = 1; c <= 4; c++) begin
            cycle();
            n_checks++; if (bus.count !== ((c == 4) ? 16'h0043 : 16'h0042))
                $display("FAIL resume_step c%0d: got %h want %h", c, bus.count, (c == 4) ? 16'h0043 : 16'h0042);
            else n_pass++;
        end
        bus.ena = 1'b0;
        repeat (10) cycle();
        n_checks++; if (bus.count !== 16'h0043) $display("FAIL ena0_hold: got %h want 0043", bus.count); else n_pass++;
        bus.ena = 1'b1;
        repeat (2) cycle();
        bus.mode = 2'b10;
        repeat (2) cycle();
        n_checks++; if (bus.count !== 16'h0042) $display("FAIL dir_switch_keeps_prescale: got %h want 0042", bus.count); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 11) == 0)
                set_in(($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)), 16'($urandom));
            if (bus.mode == 2'b11 && $urandom_range(0, 1) == 0) bus.mode = 2'($urandom_range(1, 2));
            cycle();
            n_checks++; if (bus.count !== to_bcd(m_count) || bus.wrap !== m_wrap)
                $display("FAIL rand_count c%0d: got %h %b want %h %b", c, bus.count, bus.wrap, to_bcd(m_count), m_wrap);
            else n_pass++;
            n_checks++; if (bus.segments !== m_seg || bus.digit_sel !== m_sel || bus.dp !== m_dp)
                $display("FAIL rand_disp c%0d: got %h %b %b want %h %b %b", c, bus.segments, bus.digit_sel, bus.dp, m_seg, m_sel, m_dp);
            else n_pass++;
            n_checks++; if (bus_ca.segments !== ~m_seg || bus_ca.digit_sel !== ~m_sel || bus_ca.dp !== !m_dp)
                $display("FAIL rand_ca c%0d: got %h %b %b want %h %b %b", c, bus_ca.segments, bus_ca.digit_sel, bus_ca.dp, ~m_seg, ~m_sel, !m_dp);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        set_in(1'b0, 2'b00, 16'h0000);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        test_reset();
        test_up();
        test_wrap();
        test_load_clamp();
        test_scan_lzb();
        test_hold_ena();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
